nibble_serial_alu: RTL
======================

# nibble_serial_alu

Multi-cycle, nibble-serial ALU. Computes a WIDTH-bit operation four bits per clock, LSB nibble first, using one 4-bit datapath and a registered carry between nibbles. Used wherever area matters more than latency: a requester issues operands plus a 3-bit select and waits for `done`. It uses the same select encoding as the team's combinational ALU slices.

## Interface
- `WIDTH`, default 32: operand/result width; must be a multiple of 4, ≥ 8. N = WIDTH/4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous reset, active low. Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- `start`  in  1  request pulse; sampled only in IDLE.
- `S`  in  3  operation select, captured with operands.
- `a`  in  WIDTH  operand A, captured on accept.
- `b`  in  WIDTH  operand B, captured on accept.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; result and flags valid.
- `res`  out  WIDTH  result register.
- `carry_out`  out  1  ADD/SUB carry out of MSB.
- `overflow`  out  1  ADD/SUB signed overflow.
- `zero`  out  1  `res` == 0.

## Operation
- S encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NOR
  - 100 ADD (a+b)
  - 101 SUB (a+~b+1)
  - 110 SLT (signed a<b, zero-extended 1/0)
  - 111 reserved: `res`=0, flags 0
- States: IDLE -> RUN (start=1 in IDLE) -> DONE (after nibble N-1 written) -> IDLE (unconditional, next edge).
- Accept in IDLE:
  - latch a, b, S
  - clear `res`
  - idx=0
  - carry register = 1 for SUB/SLT, else 0
- RUN, each edge:
  - nibble idx of operands through the 4-bit datapath
  - write `res[4*idx+3:4*idx]`
  - update carry register; idx++
- SUB/SLT invert B nibble before add.
- Last nibble (idx=N-1):
  - carry_out = carry out of bit WIDTH-1
  - overflow = carry into MSB XOR carry out of MSB
- SLT: on last-nibble edge, `res` <= {WIDTH-1 zeros, sign(diff) XOR overflow}. Flags carry_out/overflow reported 0 for SLT.
- Logic ops and 111: carry_out=0, overflow=0.
- `zero` registered on the DONE-entry edge from final `res` value.
- `start` in RUN or DONE is ignored, not queued.
- Inputs a, b, S may change freely after accept.
- `res` and flags hold from DONE until next accept.

## Timing
- Reset (async, any state):
  - state=IDLE; `busy`, `done`, `carry_out`, `overflow` = 0
  - `res` = 0; `zero` = 1; idx=0; carry register 0
  - Reset mid-operation aborts with no done pulse.
- Accept at edge t. Nibble k written at edge t+1+k, k=0..N-1.
- DONE entered at edge t+N: `done`=1 and all outputs valid in cycle [t+N, t+N+1).
- IDLE at edge t+N+1. Earliest next accept: edge t+N+2.
- Throughput: one op per N+2 cycles. WIDTH=32 gives 8-cycle latency to done.
- `busy` high from edge t to edge t+N+1.

## Test plan
- Post-reset check: `res`=0, `zero`=1, `busy`=0, `done`=0.
- ADD (WIDTH=32): a=0xFFFFFFFF, b=0x00000001 -> at edge t+8 `done`=1, `res`=0x00000000, carry_out=1, zero=1, overflow=0. Also a=0x12345678, b=0x11111111 -> 0x23456789, flags 0.
- SUB: a=0x80000000, b=1 -> `res`=0x7FFFFFFF, overflow=1, carry_out=1. a=5, b=5 -> `res`=0, zero=1, carry_out=1.
- SLT: a=0xFFFFFFFF, b=1 -> `res`=1. a=0x7FFFFFFF, b=0x80000000 -> `res`=0 (overflow case handled). a=b -> `res`=0, zero=1.
- Logic and reserved: XOR 0xF0F0F0F0^0xFF00FF00 -> 0x0FF00FF0. NOR 0,0 -> 0xFFFFFFFF. S=111 -> `res`=0, zero=1.
- Control:
  - start held high through an op -> exactly one done per N+2 cycles
  - start pulsed at t+3 during RUN -> ignored; operands changed after accept -> no effect
  - rst_n low at t+4 -> immediate IDLE, outputs at reset values, no done
  - new op accepted normally after release

Source files
------------

// File: rtl/nibble_serial_alu.sv
// Nibble-serial ALU: processes a WIDTH-bit operation four bits per clock, LSB
// nibble first. It uses one shared 4-bit datapath and a carry register between nibbles.
module nibble_serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       S,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       s_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;

  logic [WIDTH-1:0] a_sh, b_sh, res_d, nib_mask;
  logic [3:0]       a_nib, b_nib, b_eff, r_nib;
  logic [4:0]       sum5, low4;
  logic             last, is_sub, is_arith, is_slt, ovf_nib, slt_bit, accept;

  assign accept   = (state_q == IDLE) && start;
  assign last     = (idx_q == IW'(N - 1));
  assign is_sub   = (s_q == 3'b101) || (s_q == 3'b110);
  assign is_arith = (s_q == 3'b100) || (s_q == 3'b101);
  assign is_slt   = (s_q == 3'b110);

  // Shared 4-bit datapath fed by the nibble selected by idx_q.
  always_comb begin
    a_sh     = a_q >> {idx_q, 2'b00};
    b_sh     = b_q >> {idx_q, 2'b00};
    a_nib    = a_sh[3:0];
    b_nib    = b_sh[3:0];
    b_eff    = is_sub ? ~b_nib : b_nib;
    sum5     = {1'b0, a_nib} + {1'b0, b_eff} + {4'b0000, carry_q};
    low4     = {2'b00, a_nib[2:0]} + {2'b00, b_eff[2:0]} + {4'b0000, carry_q};
    ovf_nib  = low4[3] ^ sum5[4];
    slt_bit  = sum5[3] ^ ovf_nib;
    r_nib    = '0;
    case (s_q)
      3'b000:  r_nib = a_nib & b_nib;
      3'b001:  r_nib = a_nib | b_nib;
      3'b010:  r_nib = a_nib ^ b_nib;
      3'b011:  r_nib = ~(a_nib | b_nib);
      3'b100,
      3'b101,
      3'b110:  r_nib = sum5[3:0];
      default: r_nib = '0;
    endcase
    nib_mask = WIDTH'(4'hF) << {idx_q, 2'b00};
    res_d    = (res & ~nib_mask) | (WIDTH'(r_nib) << {idx_q, 2'b00});
    // SLT replaces the difference with the sign-corrected comparison bit.
    if (last && is_slt) res_d = WIDTH'(slt_bit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      res       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
    end else if (accept) begin
      a_q       <= a;
      b_q       <= b;
      s_q       <= S;
      idx_q     <= '0;
      carry_q   <= (S == 3'b101) || (S == 3'b110);
      res       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state_q == RUN) begin
      res     <= res_d;
      carry_q <= sum5[4];
      if (last) begin
        idx_q     <= '0;
        carry_out <= is_arith & sum5[4];
        overflow  <= is_arith & ovf_nib;
        zero      <= (res_d == '0);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
